gpu_mem_bridge: RTL and testbench
=================================

# gpu_mem_bridge

Memory responder for the GPU core: it answers the GPU's program-memory read port and data-memory read/write ports by tunnelling each request over a narrow 8-bit byte channel on the chip pins to an external host that holds the actual memories. It sits in the top-level wrapper between the `gpu` instance and the `ui_in`/`uo_out`/`uio` pins. The GPU sees an ordinary valid/ready memory. The host sees a byte-serial, strobe-acknowledged command stream.

## Interface
Parameters:
- ADDR_BITS, 8, width of program and data addresses
- PROG_BITS, 16, program word width (must be 16: two response bytes)
- DATA_BITS, 8, data word width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset; one clock domain
- prog_read_valid  in  1  GPU program fetch request; held until ready
- prog_read_address  in  ADDR_BITS  fetch address
- prog_read_ready  out  1  one-cycle completion pulse
- prog_read_data  out  PROG_BITS  fetched word; valid while ready=1
- data_read_valid  in  1  GPU data read request; held until ready
- data_read_address  in  ADDR_BITS  read address
- data_read_ready  out  1  one-cycle completion pulse
- data_read_data  out  DATA_BITS  read byte; valid while ready=1
- data_write_valid  in  1  GPU data write request; held until ready
- data_write_address  in  ADDR_BITS  write address
- data_write_data  in  DATA_BITS  write byte
- data_write_ready  out  1  one-cycle completion pulse
- bus_cmd  out  2  current transaction: 00 idle, 01 prog read, 10 data read, 11 data write
- bus_out  out  8  byte offered to the host
- bus_out_valid  out  1  bus_out holds a byte awaiting host acknowledge
- bus_in  in  8  response byte from the host
- bus_in_strobe  in  1  host strobe; each rising edge is one event, either an acknowledge or a data-valid

## Operation
- The FSM states are IDLE, SEND_ADDR, SEND_DATA, RECV_HI, RECV_LO and DONE.
- Event detection: event = strobe & ~strobe_q. A strobe held high counts once. The strobe must return low for at least 1 cycle between events.
- IDLE: arbitration is sampled only in IDLE, with fixed priority data_write > data_read > prog_read. The grant latches the command, the address and (for a write) the data.
- SEND_ADDR: bus_out=address and bus_out_valid=1. On an event:
  - write → SEND_DATA
  - data read → RECV_LO
  - prog read → RECV_HI
- SEND_DATA: bus_out=write data and bus_out_valid=1. On an event → DONE.
- RECV_HI: bus_out_valid=0. On an event, bus_in is captured into prog_read_data[15:8] → RECV_LO.
- RECV_LO: on an event, bus_in is captured into the low byte (prog_read_data[7:0] or data_read_data) → DONE.
- DONE: the matching *_ready is high for exactly 1 cycle → IDLE.
  - The requester must drop valid on the edge at which it sees ready.
  - The one IDLE cycle then re-arbitrates with the old valid already low.
- bus_cmd holds the granted command from SEND_ADDR through DONE. It is 00 in IDLE.
- In IDLE, bus_out is 0x00.
- Read data registers keep their last captured value until overwritten.
- Events that occur in IDLE or DONE are ignored.

## Timing
- Reset (async assert, sync release): state IDLE. Every output is 0, including both data registers and strobe_q.
- Reset mid-transaction abandons the transfer, and bus_cmd returns to 00 immediately. The host treats bus_cmd=00 as an abort.
- Minimum latency, with a valid first seen in cycle 0 and the fastest legal strobes:
  - data read: ready in cycle 4
  - data write: ready in cycle 4
  - prog read: ready in cycle 6
- bus_in must be stable in the cycle in which the event is detected.
- Simultaneous requests are served back to back. Each one waits in order of priority, with exactly 1 IDLE cycle between transactions.

## Configuration
- MEM_BRIDGE_SYNC_EN defined: bus_in_strobe passes through a 2-flop synchronizer before edge detection.
  - Each phase gains 2 cycles of latency.
  - The host must hold bus_in stable for ≥4 cycles after the strobe rises.
- MEM_BRIDGE_SYNC_EN undefined: the strobe is used directly. The host must drive it synchronous to clk.

## Structure
- Package gpu_mem_bridge_pkg:
  - state enum
  - bus_cmd encodings (CMD_IDLE, CMD_PROG_RD, CMD_DATA_RD, CMD_DATA_WR)
- Sub-module strobe_event: the optional synchronizer plus rising-edge detector. It outputs the one-cycle event pulse and contains the MEM_BRIDGE_SYNC_EN ifdef.

## Test plan
- Prog read, address 0x12; host acks, then returns 0xAB then 0xCD → bus_cmd=01, bus_out=0x12; prog_read_data=0xABCD with prog_read_ready high 1 cycle at cycle 6.
- Data write, address 0x34, data 0x56 → bus_cmd=11; bus_out 0x34 then 0x56, each acked; data_write_ready pulse; no capture into data_read_data.
- All three valids raised in the same cycle → served in the order write, read, prog; each ready pulses once; 1 IDLE cycle between transactions.
- Strobe held high for 10 cycles during SEND_ADDR of a data read → exactly one event; the FSM waits in RECV_LO until the strobe falls and rises again.
- rst_n low during RECV_HI of a prog read → all outputs 0 and bus_cmd=00 asynchronously; after release, a new data read completes normally.
- With MEM_BRIDGE_SYNC_EN, data read 0x07 → 0x99 → data_read_data=0x99 with ready at cycle 8.

Source files
------------

// File: rtl/gpu_mem_bridge_pkg.sv
// Shared types for gpu_mem_bridge: the transaction FSM states and the bus_cmd encodings seen by the host.
package gpu_mem_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_ADDR,
        ST_SEND_DATA,
        ST_RECV_HI,
        ST_RECV_LO,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CMD_IDLE    = 2'b00,
        CMD_PROG_RD = 2'b01,
        CMD_DATA_RD = 2'b10,
        CMD_DATA_WR = 2'b11
    } cmd_t;

endpackage

// File: rtl/gpu_mem_bridge_strobe_event.sv
// Turns the host strobe into a one-cycle event pulse per rising edge.
// Define MEM_BRIDGE_SYNC_EN to pass the strobe through a 2-flop synchronizer first.
module strobe_event (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic pulse
);

    logic strobe_in;
    logic strobe_q;

`ifdef MEM_BRIDGE_SYNC_EN
    logic [1:0] sync;

    // NOTE: async assert, sync release; every flop here clears on reset so no stale edge survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], strobe};
        end
    end

    assign strobe_in = sync[1];
`else
    assign strobe_in = strobe;
`endif

    // NOTE: non-blocking assignments for all sequential state, so flop order never matters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe_in;
        end
    end

    // A strobe held high yields exactly one pulse.
    assign pulse = strobe_in & ~strobe_q;

endmodule

// File: rtl/gpu_mem_bridge.sv
// Tunnels GPU program/data memory requests over a byte-serial, strobe-acknowledged host channel.
// Optional feature: MEM_BRIDGE_SYNC_EN (strobe synchronizer, see strobe_event).
module gpu_mem_bridge
    import gpu_mem_bridge_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int PROG_BITS = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 prog_read_valid,
    input  logic [ADDR_BITS-1:0] prog_read_address,
    output logic                 prog_read_ready,
    output logic [PROG_BITS-1:0] prog_read_data,
    input  logic                 data_read_valid,
    input  logic [ADDR_BITS-1:0] data_read_address,
    output logic                 data_read_ready,
    output logic [DATA_BITS-1:0] data_read_data,
    input  logic                 data_write_valid,
    input  logic [ADDR_BITS-1:0] data_write_address,
    input  logic [DATA_BITS-1:0] data_write_data,
    output logic                 data_write_ready,
    output logic [1:0]           bus_cmd,
    output logic [7:0]           bus_out,
    output logic                 bus_out_valid,
    input  logic [7:0]           bus_in,
    input  logic                 bus_in_strobe
);

    state_t               state;
    state_t               state_next;
    cmd_t                 cmd_q;
    cmd_t                 grant_cmd;
    logic [ADDR_BITS-1:0] addr_q;
    logic [ADDR_BITS-1:0] grant_addr;
    logic [DATA_BITS-1:0] wdata_q;
    logic [PROG_BITS-1:0] prog_data_q;
    logic [DATA_BITS-1:0] data_rd_q;
    logic                 ev;

    strobe_event u_strobe_event (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (bus_in_strobe),
        .pulse  (ev)
    );

    // Fixed priority: write > read > fetch, only ever evaluated in IDLE.
    always_comb begin
        grant_cmd  = CMD_IDLE;
        grant_addr = '0;
        if (data_write_valid) begin
            grant_cmd  = CMD_DATA_WR;
            grant_addr = data_write_address;
        end else if (data_read_valid) begin
            grant_cmd  = CMD_DATA_RD;
            grant_addr = data_read_address;
        end else if (prog_read_valid) begin
            grant_cmd  = CMD_PROG_RD;
            grant_addr = prog_read_address;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cmd_q       <= CMD_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            prog_data_q <= '0;
            data_rd_q   <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && grant_cmd != CMD_IDLE) begin
                cmd_q   <= grant_cmd;
                addr_q  <= grant_addr;
                wdata_q <= data_write_data;
            end
            if (ev && state == ST_RECV_HI) begin
                prog_data_q[PROG_BITS-1 -: 8] <= bus_in;
            end
            if (ev && state == ST_RECV_LO) begin
                if (cmd_q == CMD_PROG_RD) begin
                    prog_data_q[7:0] <= bus_in;
                end else begin
                    data_rd_q <= DATA_BITS'(bus_in);
                end
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next       = state;
        bus_out          = 8'h00;
        bus_out_valid    = 1'b0;
        prog_read_ready  = 1'b0;
        data_read_ready  = 1'b0;
        data_write_ready = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (grant_cmd != CMD_IDLE) state_next = ST_SEND_ADDR;
            end
            ST_SEND_ADDR: begin
                bus_out       = 8'(addr_q);
                bus_out_valid = 1'b1;
                if (ev) begin
                    unique case (cmd_q)
                        CMD_DATA_WR: state_next = ST_SEND_DATA;
                        CMD_DATA_RD: state_next = ST_RECV_LO;
                        default:     state_next = ST_RECV_HI;
                    endcase
                end
            end
            ST_SEND_DATA: begin
                bus_out       = 8'(wdata_q);
                bus_out_valid = 1'b1;
                if (ev) state_next = ST_DONE;
            end
            ST_RECV_HI: begin
                if (ev) state_next = ST_RECV_LO;
            end
            ST_RECV_LO: begin
                if (ev) state_next = ST_DONE;
            end
            ST_DONE: begin
                prog_read_ready  = (cmd_q == CMD_PROG_RD);
                data_read_ready  = (cmd_q == CMD_DATA_RD);
                data_write_ready = (cmd_q == CMD_DATA_WR);
                state_next       = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The host reads bus_cmd=00 as an abort, so it must drop with the state on reset.
    assign bus_cmd        = (state == ST_IDLE) ? CMD_IDLE : cmd_q;
    assign prog_read_data = prog_data_q;
    assign data_read_data = data_rd_q;

endmodule

// File: tb/tb_gpu_mem_bridge.sv
// Scoreboard bench for gpu_mem_bridge (default build): a host model answers the byte channel.
module tb_gpu_mem_bridge;
    import gpu_mem_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prog_read_valid = 1'b0;
    logic [7:0]  prog_read_address = '0;
    logic        prog_read_ready;
    logic [15:0] prog_read_data;
    logic        data_read_valid = 1'b0;
    logic [7:0]  data_read_address = '0;
    logic        data_read_ready;
    logic [7:0]  data_read_data;
    logic        data_write_valid = 1'b0;
    logic [7:0]  data_write_address = '0;
    logic [7:0]  data_write_data = '0;
    logic        data_write_ready;
    logic [1:0]  bus_cmd;
    logic [7:0]  bus_out;
    logic        bus_out_valid;
    logic [7:0]  bus_in = '0;
    logic        bus_in_strobe = 1'b0;

    gpu_mem_bridge dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .prog_read_valid    (prog_read_valid),
        .prog_read_address  (prog_read_address),
        .prog_read_ready    (prog_read_ready),
        .prog_read_data     (prog_read_data),
        .data_read_valid    (data_read_valid),
        .data_read_address  (data_read_address),
        .data_read_ready    (data_read_ready),
        .data_read_data     (data_read_data),
        .data_write_valid   (data_write_valid),
        .data_write_address (data_write_address),
        .data_write_data    (data_write_data),
        .data_write_ready   (data_write_ready),
        .bus_cmd            (bus_cmd),
        .bus_out            (bus_out),
        .bus_out_valid      (bus_out_valid),
        .bus_in             (bus_in),
        .bus_in_strobe      (bus_in_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        cmd_t        cmd;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [15:0] rdata;
    } txn_t;

    txn_t        sb[$];
    logic [15:0] prog_mem [256];
    logic [7:0]  data_mem [256];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;

    // Host model state.
    int          phase = 0;
    int          hold_ctr = 0;
    int          cur_hold = 1;
    int          first_hold = 1;
    logic [7:0]  host_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int n_phases(input logic [1:0] c);
        case (c)
            CMD_PROG_RD: return 3;
            CMD_DATA_RD: return 2;
            CMD_DATA_WR: return 2;
            default:     return 0;
        endcase
    endfunction

    function automatic logic ready_of(input cmd_t c);
        case (c)
            CMD_PROG_RD: return prog_read_ready;
            CMD_DATA_RD: return data_read_ready;
            default:     return data_write_ready;
        endcase
    endfunction

    task automatic push_exp(input cmd_t c, input logic [7:0] a, input logic [7:0] wd);
        txn_t t;
        t.cmd   = c;
        t.addr  = a;
        t.wdata = wd;
        t.rdata = (c == CMD_PROG_RD) ? prog_mem[a] : {8'h00, data_mem[a]};
        sb.push_back(t);
    endtask

    // Fastest legal host: strobe one cycle high, one low, per phase.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            bus_in_strobe = 1'b0;
            phase = 0;
        end else if (bus_in_strobe) begin
            if (hold_ctr >= cur_hold) bus_in_strobe = 1'b0;
            else hold_ctr++;
        end else if (bus_cmd == CMD_IDLE) begin
            phase = 0;
        end else if (phase < n_phases(bus_cmd)) begin
            if (phase == 0) begin
                host_addr = bus_out;
                check("host_addr_valid", bus_out_valid, 1);
                if (sb.size() > 0) begin
                    check("host_cmd", bus_cmd, sb[0].cmd);
                    check("host_addr", bus_out, sb[0].addr);
                end
                cur_hold = first_hold;
            end else begin
                cur_hold = 1;
                if (bus_cmd == CMD_DATA_WR) begin
                    check("host_wdata_valid", bus_out_valid, 1);
                    if (sb.size() > 0) check("host_wdata", bus_out, sb[0].wdata);
                    data_mem[host_addr] = bus_out;
                end else begin
                    check("host_rx_valid", bus_out_valid, 0);
                    if (bus_cmd == CMD_DATA_RD) bus_in = data_mem[host_addr];
                    else if (phase == 1) bus_in = prog_mem[host_addr][15:8];
                    else bus_in = prog_mem[host_addr][7:0];
                end
            end
            bus_in_strobe = 1'b1;
            hold_ctr = 1;
            phase++;
        end
    end

    // Scoreboard: pop one expected transaction per ready pulse.
    always @(negedge clk) begin
        logic [2:0] rdy;
        txn_t       e;
        rdy = {prog_read_ready, data_read_ready, data_write_ready};
        if (rst_n && rdy != 3'b000) begin
            check("ready_onehot", $countones(rdy), 1);
            if (sb.size() == 0) begin
                check("ready_unexpected", rdy, 3'b000);
            end else begin
                e = sb.pop_front();
                case (e.cmd)
                    CMD_PROG_RD: begin
                        check("ready_kind", rdy, 3'b100);
                        check("prog_data", prog_read_data, e.rdata);
                    end
                    CMD_DATA_RD: begin
                        check("ready_kind", rdy, 3'b010);
                        check("data_rd", data_read_data, e.rdata);
                    end
                    default: check("ready_kind", rdy, 3'b001);
                endcase
            end
        end
    end

    // Raise one request, wait for its ready, drop valid on the edge after it.
    task automatic do_req(input cmd_t c, input logic [7:0] a, input logic [7:0] wd, input int exp_lat);
        int   t0;
        logic got;
        @(posedge clk);
        #1;
        case (c)
            CMD_PROG_RD: begin prog_read_valid = 1'b1; prog_read_address = a; end
            CMD_DATA_RD: begin data_read_valid = 1'b1; data_read_address = a; end
            default: begin data_write_valid = 1'b1; data_write_address = a; data_write_data = wd; end
        endcase
        t0  = cyc;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (ready_of(c)) got = 1'b1;
        end
        if (!got) check("ready_timeout", 0, 1);
        else check("latency", cyc - t0, exp_lat);
        @(posedge clk);
        #1;
        case (c)
            CMD_PROG_RD: prog_read_valid = 1'b0;
            CMD_DATA_RD: data_read_valid = 1'b0;
            default:     data_write_valid = 1'b0;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd_before;
        for (int i = 0; i < 256; i++) begin
            prog_mem[i] = {8'(i) ^ 8'hA5, 8'(i) + 8'h3C};
            data_mem[i] = 8'(i * 3 + 1);
        end
        prog_mem[8'h12] = 16'hABCD;
        data_mem[8'h07] = 8'h99;

        #23;
        check("rst_bus_cmd", bus_cmd, 0);
        check("rst_bus_out", bus_out, 0);
        check("rst_bus_out_valid", bus_out_valid, 0);
        check("rst_prog_data", prog_read_data, 0);
        check("rst_data_rd", data_read_data, 0);
        check("rst_readies", {prog_read_ready, data_read_ready, data_write_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        push_exp(CMD_DATA_RD, 8'h07, 8'h00);
        do_req(CMD_DATA_RD, 8'h07, 8'h00, 4);
        idle(2);

        push_exp(CMD_PROG_RD, 8'h12, 8'h00);
        do_req(CMD_PROG_RD, 8'h12, 8'h00, 6);
        idle(2);

        rd_before = data_read_data;
        push_exp(CMD_DATA_WR, 8'h34, 8'h56);
        do_req(CMD_DATA_WR, 8'h34, 8'h56, 4);
        check("wr_no_capture", data_read_data, rd_before);
        idle(2);

        // All three at once: write, read, fetch with one IDLE cycle between.
        push_exp(CMD_DATA_WR, 8'h40, 8'h77);
        push_exp(CMD_DATA_RD, 8'h41, 8'h00);
        push_exp(CMD_PROG_RD, 8'h42, 8'h00);
        fork
            do_req(CMD_DATA_WR, 8'h40, 8'h77, 4);
            do_req(CMD_DATA_RD, 8'h41, 8'h00, 9);
            do_req(CMD_PROG_RD, 8'h42, 8'h00, 16);
        join
        check("sb_drained", sb.size(), 0);
        idle(2);

        // First strobe held 10 cycles must count once.
        first_hold = 10;
        push_exp(CMD_DATA_RD, 8'h09, 8'h00);
        do_req(CMD_DATA_RD, 8'h09, 8'h00, 13);
        first_hold = 1;
        idle(2);

        // Reset during RECV_HI of a fetch.
        push_exp(CMD_PROG_RD, 8'h20, 8'h00);
        @(posedge clk);
        #1;
        prog_read_valid = 1'b1;
        prog_read_address = 8'h20;
        @(posedge clk);
        @(posedge clk);
        #3;
        check("pre_rst_bus_cmd", bus_cmd, CMD_PROG_RD);
        check("pre_rst_bus_out_valid", bus_out_valid, 0);
        rst_n = 1'b0;
        prog_read_valid = 1'b0;
        #1;
        check("arst_bus_cmd", bus_cmd, 0);
        check("arst_bus_out", bus_out, 0);
        check("arst_prog_data", prog_read_data, 0);
        check("arst_data_rd", data_read_data, 0);
        check("arst_readies", {prog_read_ready, data_read_ready, data_write_ready}, 0);
        sb.delete();
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        push_exp(CMD_DATA_RD, 8'h55, 8'h00);
        do_req(CMD_DATA_RD, 8'h55, 8'h00, 4);
        idle(3);
        check("sb_final", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
